// File: rtl/reg_wr_arb_fpga.sv
`default_nettype none
// ============================================================================
// Module   : reg_wr_arb_fpga
// Purpose  : ALU/LSU writeback arbiter with per-source FIFOs. It drives the single
//            write port of the 3R/1W vector register bank.
// Option   : REG_WR_ARB_LSU_PRIO_EN selects fixed LSU priority. The default is round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module reg_wr_arb_fpga #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_wr_valid,
    output logic        alu_wr_ready,
    input  logic [9:0]  alu_wr_addr,
    input  logic [31:0] alu_wr_data,
    input  logic        lsu_wr_valid,
    output logic        lsu_wr_ready,
    input  logic [9:0]  lsu_wr_addr,
    input  logic [31:0] lsu_wr_data,
    output logic        wr0_en,
    output logic [9:0]  wr0_addr,
    output logic [31:0] wr0_data,
    output logic        idle
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_ent_w = 42;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    // Index 0 is the ALU and index 1 is the LSU throughout.
    logic [1:0]              w_push;
    logic [1:0]              w_gnt;
    logic [1:0]              w_ne;
    logic [1:0]              w_rdy;
    logic [1:0]              w_contest_gnt;
    logic [1:0][c_ent_w-1:0] w_in;
    logic [1:0][c_ent_w-1:0] w_head;

    assign w_in[0] = {alu_wr_addr, alu_wr_data};
    assign w_in[1] = {lsu_wr_addr, lsu_wr_data};
    assign w_push  = {lsu_wr_valid & w_rdy[1], alu_wr_valid & w_rdy[0]};

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [c_ent_w-1:0] r_mem [DEPTH];
        logic [c_ptr_w-1:0] r_wp;
        logic [c_ptr_w-1:0] r_rp;
        logic [c_cnt_w-1:0] r_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push[gi]) r_wp <= r_wp + 1'b1;
                if (w_gnt[gi])  r_rp <= r_rp + 1'b1;
                if (w_push[gi] && !w_gnt[gi])
                    r_cnt <= r_cnt + 1'b1;
                else if (!w_push[gi] && w_gnt[gi])
                    r_cnt <= r_cnt - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_push[gi]) r_mem[r_wp] <= w_in[gi];
        end

        assign w_head[gi] = r_mem[r_rp];
        assign w_ne[gi]   = (r_cnt != '0);
        // Ready depends on the count alone, so a full FIFO refuses a push even when it pops.
        assign w_rdy[gi]  = (r_cnt != c_full) && !rst;
    end

`ifdef REG_WR_ARB_LSU_PRIO_EN
    assign w_contest_gnt = 2'b10;
`else
    logic r_rr_lsu;

    assign w_contest_gnt = r_rr_lsu ? 2'b10 : 2'b01;

    // Only contested grants move the pointer. It then favours the other source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rr_lsu <= 1'b0;
        else if (&w_ne)
            r_rr_lsu <= w_contest_gnt[0];
    end
`endif

    always_comb begin
        w_gnt = 2'b00;
        case (w_ne)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = w_contest_gnt;
            default: w_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr0_en   <= 1'b0;
            wr0_addr <= '0;
            wr0_data <= '0;
        end else begin
            wr0_en <= |w_gnt;
            if (w_gnt[1])
                {wr0_addr, wr0_data} <= w_head[1];
            else if (w_gnt[0])
                {wr0_addr, wr0_data} <= w_head[0];
        end
    end

    assign alu_wr_ready = w_rdy[0];
    assign lsu_wr_ready = w_rdy[1];
    assign idle         = ~|w_ne & ~wr0_en;

endmodule
`default_nettype wire

// File: tb/tb_reg_wr_arb_fpga.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_wr_arb_fpga
// Purpose  : Directed self-checking bench for reg_wr_arb_fpga. Its expectations follow
//            REG_WR_ARB_LSU_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_wr_arb_fpga;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_wr_valid = 1'b0;
    logic        alu_wr_ready;
    logic [9:0]  alu_wr_addr = '0;
    logic [31:0] alu_wr_data = '0;
    logic        lsu_wr_valid = 1'b0;
    logic        lsu_wr_ready;
    logic [9:0]  lsu_wr_addr = '0;
    logic [31:0] lsu_wr_data = '0;
    logic        wr0_en;
    logic [9:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        idle;

    int n_cmp  = 0;
    int n_fail = 0;
    int a_seq, l_seq, a_lim, l_lim;

    reg_wr_arb_fpga #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_wr_valid (alu_wr_valid),
        .alu_wr_ready (alu_wr_ready),
        .alu_wr_addr  (alu_wr_addr),
        .alu_wr_data  (alu_wr_data),
        .lsu_wr_valid (lsu_wr_valid),
        .lsu_wr_ready (lsu_wr_ready),
        .lsu_wr_addr  (lsu_wr_addr),
        .lsu_wr_data  (lsu_wr_data),
        .wr0_en       (wr0_en),
        .wr0_addr     (wr0_addr),
        .wr0_data     (wr0_data),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The producers hold each request until it is accepted, then present their next sequence number.
    task automatic stream_tick();
        logic a_acc, l_acc;
        a_acc = alu_wr_valid & alu_wr_ready;
        l_acc = lsu_wr_valid & lsu_wr_ready;
        tick();
        if (a_acc) a_seq++;
        if (l_acc) l_seq++;
        alu_wr_valid = (a_seq < a_lim);
        lsu_wr_valid = (l_seq < l_lim);
        alu_wr_addr  = 10'h100 + 10'(a_seq);
        alu_wr_data  = 32'hA000_0000 + 32'(a_seq);
        lsu_wr_addr  = 10'h200 + 10'(l_seq);
        lsu_wr_data  = 32'hB000_0000 + 32'(l_seq);
    endtask

    initial begin
        logic [9:0]  exp_addr;
        logic [31:0] exp_data;
        int          n_alu;

        // ---------------- reset ----------------
        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_wr0_en", 64'(wr0_en), 64'd0);
        chk("rst_wr0_addr", 64'(wr0_addr), 64'd0);
        chk("rst_wr0_data", 64'(wr0_data), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_alu_ready", 64'(alu_wr_ready), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_wr_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_alu_ready", 64'(alu_wr_ready), 64'd1);
        chk("post_rst_lsu_ready", 64'(lsu_wr_ready), 64'd1);

        // ---------------- single ALU push ----------------
        tick();
        alu_wr_valid = 1'b1; alu_wr_addr = 10'h015; alu_wr_data = 32'hDEADBEEF;
        tick();
        alu_wr_valid = 1'b0;
        chk("single_en_n", 64'(wr0_en), 64'd0);
        chk("single_idle_n", 64'(idle), 64'd0);
        tick();
        chk("single_en_n1", 64'(wr0_en), 64'd1);
        chk("single_addr", 64'(wr0_addr), 64'h015);
        chk("single_data", 64'(wr0_data), 64'hDEADBEEF);
        tick();
        chk("single_en_n2", 64'(wr0_en), 64'd0);
        chk("single_idle_n2", 64'(idle), 64'd1);
        chk("single_addr_hold", 64'(wr0_addr), 64'h015);

        // ---------------- simultaneous push ----------------
        alu_wr_valid = 1'b1; alu_wr_addr = 10'h001; alu_wr_data = 32'h11111111;
        lsu_wr_valid = 1'b1; lsu_wr_addr = 10'h002; lsu_wr_data = 32'h22222222;
        tick();
        alu_wr_valid = 1'b0; lsu_wr_valid = 1'b0;
        chk("dual_en_n", 64'(wr0_en), 64'd0);
        tick();
`ifdef REG_WR_ARB_LSU_PRIO_EN
        chk("dual_first_addr", 64'(wr0_addr), 64'h002);
        chk("dual_first_data", 64'(wr0_data), 64'h22222222);
`else
        chk("dual_first_addr", 64'(wr0_addr), 64'h001);
        chk("dual_first_data", 64'(wr0_data), 64'h11111111);
`endif
        chk("dual_first_en", 64'(wr0_en), 64'd1);
        tick();
`ifdef REG_WR_ARB_LSU_PRIO_EN
        chk("dual_second_addr", 64'(wr0_addr), 64'h001);
        chk("dual_second_data", 64'(wr0_data), 64'h11111111);
`else
        chk("dual_second_addr", 64'(wr0_addr), 64'h002);
        chk("dual_second_data", 64'(wr0_data), 64'h22222222);
`endif
        chk("dual_second_en", 64'(wr0_en), 64'd1);
        tick();
        chk("dual_done_en", 64'(wr0_en), 64'd0);
        chk("dual_done_idle", 64'(idle), 64'd1);

`ifdef REG_WR_ARB_LSU_PRIO_EN
        // ---------------- LSU priority starves the ALU until the LSU stops ----------------
        a_seq = 0; l_seq = 0; a_lim = DEPTH + 1; l_lim = 1000;
        alu_wr_valid = 1'b1; alu_wr_addr = 10'h100; alu_wr_data = 32'hA000_0000;
        lsu_wr_valid = 1'b1; lsu_wr_addr = 10'h200; lsu_wr_data = 32'hB000_0000;
        for (int k = 0; k <= 7; k++) begin
            stream_tick();
            if (k == 3) chk("prio_alu_ready_full", 64'(alu_wr_ready), 64'd0);
            if (k >= 1) chk("prio_lsu_granted", 64'({wr0_en, wr0_addr[9:8]}), 64'b110);
        end
        l_lim = l_seq;
        lsu_wr_valid = 1'b0;
        n_alu = 0;
        for (int k = 0; k < 30; k++) begin
            stream_tick();
            if (wr0_en && wr0_addr[9:8] == 2'b01) begin
                exp_addr = 10'h100 + 10'(n_alu);
                exp_data = 32'hA000_0000 + 32'(n_alu);
                chk("prio_alu_order_addr", 64'(wr0_addr), 64'(exp_addr));
                chk("prio_alu_order_data", 64'(wr0_data), 64'(exp_data));
                n_alu++;
            end
        end
        chk("prio_alu_count", 64'(n_alu), 64'd5);
        chk("prio_idle", 64'(idle), 64'd1);
`else
        // ---------------- round-robin streaming (pointer now favours the LSU) ----------------
        a_seq = 0; l_seq = 0; a_lim = 1000; l_lim = 1000;
        alu_wr_valid = 1'b1; alu_wr_addr = 10'h100; alu_wr_data = 32'hA000_0000;
        lsu_wr_valid = 1'b1; lsu_wr_addr = 10'h200; lsu_wr_data = 32'hB000_0000;
        for (int k = 0; k <= 12; k++) begin
            stream_tick();
            if (k == 0) begin
                chk("rr_en_first", 64'(wr0_en), 64'd0);
            end else begin
                if ((k - 1) % 2 == 0) begin
                    exp_addr = 10'h200 + 10'((k - 1) / 2);
                    exp_data = 32'hB000_0000 + 32'((k - 1) / 2);
                end else begin
                    exp_addr = 10'h100 + 10'((k - 1) / 2);
                    exp_data = 32'hA000_0000 + 32'((k - 1) / 2);
                end
                chk("rr_en", 64'(wr0_en), 64'd1);
                chk("rr_addr", 64'(wr0_addr), 64'(exp_addr));
                chk("rr_data", 64'(wr0_data), 64'(exp_data));
            end
            // The ALU fills first and the two FIFOs then take turns being full.
            if (k == 5) chk("rr_full_ready_k5", 64'({alu_wr_ready, lsu_wr_ready}), 64'b01);
            if (k == 6) chk("rr_full_ready_k6", 64'({alu_wr_ready, lsu_wr_ready}), 64'b10);
            if (k == 7) chk("rr_full_ready_k7", 64'({alu_wr_ready, lsu_wr_ready}), 64'b01);
        end
        alu_wr_valid = 1'b0;
        lsu_wr_valid = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) tick();
        chk("rr_drain_idle", 64'(idle), 64'd1);
`endif

        // ---------------- asynchronous reset with entries queued ----------------
        alu_wr_valid = 1'b1; alu_wr_addr = 10'h3F0; alu_wr_data = 32'hCAFE0001;
        lsu_wr_valid = 1'b1; lsu_wr_addr = 10'h3F1; lsu_wr_data = 32'hCAFE0002;
        tick();
        tick();
        alu_wr_valid = 1'b0;
        lsu_wr_valid = 1'b0;
        chk("flush_pre_en", 64'(wr0_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("flush_async_en", 64'(wr0_en), 64'd0);
        chk("flush_async_addr", 64'(wr0_addr), 64'd0);
        chk("flush_ready", 64'({alu_wr_ready, lsu_wr_ready}), 64'b00);
        chk("flush_idle", 64'(idle), 64'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_no_stale_en", 64'(wr0_en), 64'd0);
            chk("flush_no_stale_idle", 64'(idle), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_wr_arb_fpga.md
# reg_wr_arb_fpga

Write-port arbiter that sits directly upstream of the FPGA 3-read/1-write vector register bank and drives its single write port. It accepts register writebacks from two independent producers (ALU writeback, LSU load return), buffers each in a small FIFO, and issues at most one write per clock. Each source can stall on `ready`. The arbiter guarantees that no write is dropped when both producers complete in the same cycle.

## Interface
Parameters:
- `DEPTH`, 4: entries per source FIFO. Must be a power of two, ≥2.

Ports:
- `clk` input 1: sole clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `alu_wr_valid` input 1: ALU write request.
- `alu_wr_ready` output 1: ALU FIFO can accept.
- `alu_wr_addr` input 10: register address.
- `alu_wr_data` input 32: write data.
- `lsu_wr_valid` input 1: LSU write request.
- `lsu_wr_ready` output 1: LSU FIFO can accept.
- `lsu_wr_addr` input 10: register address.
- `lsu_wr_data` input 32: write data.
- `wr0_en` output 1: write strobe to the register bank.
- `wr0_addr` output 10: write address to the register bank.
- `wr0_data` output 32: write data to the register bank.
- `idle` output 1: both FIFOs empty and `wr0_en` low.

## Operation
- Each source has its own FIFO of `DEPTH` entries (addr+data, 42 bits).
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Each FIFO has a count of log2(DEPTH)+1 bits.
- `x_wr_ready` = (count != DEPTH) and not `rst`. It is combinational from count only; a pop in the same cycle does not free a slot.
- Push: `x_wr_valid & x_wr_ready` at a rising edge writes the entry and increments count.
  - `valid` while not ready is ignored. The source must hold the request.
- Arbitration runs every cycle on the FIFO heads:
  - Neither FIFO non-empty: no grant.
  - Exactly one non-empty: grant it.
  - Both non-empty: grant per the priority policy (see Configuration).
- On grant, the head is popped. `wr0_en`/`wr0_addr`/`wr0_data` are registered from the granted head at the same edge.
  - With no grant, `wr0_en`=0 next cycle and addr/data hold their last values.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
- Ordering:
  - FIFO order is preserved within a source.
  - Across sources, the order is the arbitration order only. Same-address writes from both sources in one cycle land in grant order; the last one wins.
- Reset mid-operation flushes all queued entries. Flushed writes are lost; producers must not assume completion.
- Reset values:
  - `wr0_en`=0, `wr0_addr`=0, `wr0_data`=0.
  - Pointers and counts are 0.
  - Round-robin pointer is set to favour ALU.
  - `idle`=1.
  - Both readies are 0 while `rst` is high, and 1 after deassertion.

## Timing
- A push accepted at edge N makes the entry visible at the FIFO head in cycle N+1. Minimum latency is 2 cycles from `valid` to `wr0_en`.
- Steady-state throughput is one write per cycle total, shared between the two sources.
- The register bank has 1-cycle read latency. A read of an address issued in the same cycle `wr0_en` is high returns old data, and this block does not forward.

## Configuration
- `REG_WR_ARB_LSU_PRIO_EN`:
  - Defined: LSU has fixed priority whenever both FIFOs are non-empty. The ALU can starve while the LSU stays non-empty.
  - Undefined (default): round-robin. After each contested grant, the pointer favours the source not just granted. Uncontested grants do not move the pointer.

## Test plan
- Reset then single ALU push (addr 0x015, data 0xDEADBEEF) at edge N -> `wr0_en`=1 with addr 0x015 and data 0xDEADBEEF in cycle N+2 only; `idle` returns to 1 at N+3.
- ALU and LSU push on the same edge (0x001/0x11111111 and 0x002/0x22222222), macro undefined -> ALU write at N+2, LSU write at N+3; macro defined -> LSU first, then ALU.
- ALU pushes DEPTH+1 entries back-to-back with the LSU continuously busy under LSU priority -> `alu_wr_ready` drops once count is 4; no entry lost or reordered once LSU traffic stops.
- Both sources streaming continuously under round-robin -> `wr0_en` high every cycle, grants alternate ALU/LSU exactly.
- Full FIFO with pop and push attempted in the same cycle -> push refused (`ready`=0); count goes 4→3; accepted on the next cycle.
- Assert `rst` with 3 entries queued -> `wr0_en`=0 immediately (asynchronous), readies 0; after release `idle`=1 and no stale writes are issued.
